// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port unified instruction/data memory between the fetch
//   stage (IF) and the memory stage (MEM). A three-state FSM (IDLE, BUSY, RESP)
//   serializes the accesses. Each access holds the memory for WAIT_CYCLES+1
//   cycles. It then returns a one-cycle ready pulse to the port that won.
//
//   Optional feature: define ARB_FAIRNESS_EN to make ties alternate between
//   the ports. Without the macro, MEM always wins a tie.
//
// Ports
//   clk, reset                 rising-edge clock, async active-low reset
//   if_req/if_addr             fetch request (held until if_ready)
//   if_rdata/if_ready          fetched word and one-cycle completion pulse
//   dm_req/dm_we/dm_addr/      data request (held until dm_ready)
//   dm_wdata
//   dm_rdata/dm_ready          read data and one-cycle completion pulse
//   mem_en/mem_we/mem_addr/    memory macro controls (decoded from state)
//   mem_wdata/mem_rdata
//   grant                      current owner: 00 none, 01 IF, 10 MEM
module mem_port_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        grant
);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    localparam logic [1:0] GrantNone = 2'b00;
    localparam logic [1:0] GrantIf   = 2'b01;
    localparam logic [1:0] GrantDm   = 2'b10;
    localparam logic [3:0] WaitInit  = WAIT_CYCLES[3:0];

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              dm_ready_q, dm_ready_d;
    logic              pick_dm;

`ifdef ARB_FAIRNESS_EN
    // Which port won the most recent grant (0 = IF, 1 = MEM).
    logic last_dm_q, last_dm_d;

    // On a tie, the port that did not win last time goes first.
    assign pick_dm = dm_req & (~if_req | ~last_dm_q);

    always_comb begin
        last_dm_d = last_dm_q;
        if (state_q == StIdle && (if_req || dm_req)) begin
            last_dm_d = pick_dm;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_dm_q <= 1'b0;
        end else begin
            last_dm_q <= last_dm_d;
        end
    end
`else
    // MEM is the older instruction in the pipeline, so it wins a tie.
    assign pick_dm = dm_req;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_ready_d = 1'b0;
        dm_ready_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (if_req || dm_req) begin
                    if (pick_dm) begin
                        addr_d  = dm_addr;
                        wdata_d = dm_wdata;
                        we_d    = dm_we;
                        grant_d = GrantDm;
                    end else begin
                        addr_d  = if_addr;
                        wdata_d = '0;
                        we_d    = 1'b0;
                        grant_d = GrantIf;
                    end
                    cnt_d   = WaitInit;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Last BUSY cycle: mem_rdata is valid now.
                    if (!we_q) begin
                        if (grant_q == GrantIf) begin
                            if_rdata_d = mem_rdata;
                        end else begin
                            dm_rdata_d = mem_rdata;
                        end
                    end
                    if_ready_d = (grant_q == GrantIf);
                    dm_ready_d = (grant_q == GrantDm);
                    state_d    = StResp;
                end
            end
            StResp: begin
                grant_d = GrantNone;
                state_d = StIdle;
            end
            default: begin
                grant_d = GrantNone;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            grant_q    <= GrantNone;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_ready_q <= if_ready_d;
            dm_ready_q <= dm_ready_d;
        end
    end

    // Memory controls are driven only while BUSY, so a reset drops them at once.
    always_comb begin
        mem_en    = (state_q == StBusy);
        mem_we    = mem_en & we_q;
        mem_addr  = mem_en ? addr_q : '0;
        mem_wdata = mem_en ? wdata_q : '0;
    end

    assign grant    = grant_q;
    assign if_rdata = if_rdata_q;
    assign dm_rdata = dm_rdata_q;
    assign if_ready = if_ready_q;
    assign dm_ready = dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Bench for mem_port_arbiter. It runs in four parts:
//     - a table of single transactions;
//     - hand-written sequences for reset, tie and back-to-back traffic;
//     - a second instance built with WAIT_CYCLES = 0;
//     - a random run checked against a transaction-level timeline model.
//   A behavioural memory sits on the memory port of each instance.
module tb_mem_port_arbiter;

    localparam int W = 1;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ready, dm_ready, mem_en, mem_we;
    logic [1:0]  grant;

    logic        if_req0;
    logic [31:0] if_addr0;
    logic [31:0] if_rdata0, dm_rdata0, mem_addr0, mem_wdata0, mem_rdata0;
    logic        if_ready0, dm_ready0, mem_en0, mem_we0;
    logic [1:0]  grant0;

    int n_chk  = 0;
    int n_pass = 0;
    int ecnt   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .grant(grant)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .if_req(if_req0), .if_addr(if_addr0), .if_rdata(if_rdata0), .if_ready(if_ready0),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
        .dm_rdata(dm_rdata0), .dm_ready(dm_ready0),
        .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .mem_rdata(mem_rdata0), .grant(grant0)
    );

    // Untouched locations return a pattern derived from the address.
    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a == 32'h10) ? 32'hE3A0_0007 : {16'hC0DE, 8'h00, a[7:0]};
    endfunction

    // Behavioural memory seen by the main instance.
    logic [31:0] tmem [64];
    logic [63:0] twr = '0;
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            tmem[mem_addr[7:2]] <= mem_wdata;
            twr[mem_addr[7:2]]  <= 1'b1;
        end
    end
    assign mem_rdata  = twr[mem_addr[7:2]] ? tmem[mem_addr[7:2]] : init_val(mem_addr);
    assign mem_rdata0 = mem_addr0 ^ 32'h5A5A_0000;

    // Reference view of the memory, updated by the model on completed writes.
    logic [31:0] ref_mem [64];
    logic [63:0] ref_wr = '0;
    logic [31:0] exp_if_rd = '0;
    logic [31:0] exp_dm_rd = '0;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_wr[a[7:2]] ? ref_mem[a[7:2]] : init_val(a);
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d);
        ref_mem[a[7:2]] = d;
        ref_wr[a[7:2]]  = 1'b1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps from the sampling edge until a ready pulse (bounded).
    task automatic txn(output int n, output int en, output logic [1:0] rdy,
                       output logic [1:0] g, output logic [31:0] a, output logic w,
                       output logic [31:0] wd);
        step();
        n  = 1;
        en = int'(mem_en);
        g  = grant;
        a  = mem_addr;
        w  = mem_we;
        wd = mem_wdata;
        while (!(if_ready || dm_ready) && n < 12) begin
            step();
            n++;
            en += int'(mem_en);
        end
        rdy = {dm_ready, if_ready};
    endtask

    typedef struct {
        logic        ifr;
        logic        dmr;
        logic        we;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] wd;
        logic [1:0]  g;
        logic [31:0] ea;
        logic        ewe;
    } vec_t;

    vec_t        vt [7];
    int          n, en;
    logic [1:0]  rdy, g;
    logic [31:0] a, wd;
    logic        w;
    logic [1:0]  gs [3];
    logic [1:0]  gs_exp [3];
    logic        exp_pend;

    // Random-phase timeline model state.
    int          s_edge, nf, e1, e;
    logic [1:0]  cp;
    logic        cwe, lw, win_dm;
    logic [31:0] ca, cwd;

    initial begin
        vt[0] = '{1'b1, 1'b0, 1'b0, 32'h10, 32'h0,  32'h0,         2'b01, 32'h10, 1'b0};
        vt[1] = '{1'b1, 1'b1, 1'b1, 32'h14, 32'h64, 32'h7,         2'b10, 32'h64, 1'b1};
        vt[2] = '{1'b0, 1'b1, 1'b0, 32'h0,  32'h64, 32'h0,         2'b10, 32'h64, 1'b0};
        vt[3] = '{1'b0, 1'b1, 1'b1, 32'h0,  32'h20, 32'hDEADBEEF,  2'b10, 32'h20, 1'b1};
        vt[4] = '{1'b1, 1'b0, 1'b0, 32'h20, 32'h0,  32'h0,         2'b01, 32'h20, 1'b0};
        vt[5] = '{1'b1, 1'b1, 1'b0, 32'h64, 32'h10, 32'h0,         2'b10, 32'h10, 1'b0};
        vt[6] = '{1'b1, 1'b0, 1'b0, 32'hFC, 32'h0,  32'h0,         2'b01, 32'hFC, 1'b0};

        // Reset held with a pending fetch: everything stays at zero.
        reset = 1'b0;
        if_req = 1'b1; if_addr = 32'h10;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        if_req0 = 1'b0; if_addr0 = '0;
        #1;
        chk("rst_ctl_async", 32'({grant, if_ready, dm_ready, mem_en, mem_we}), 32'h0);
        repeat (3) step();
        chk("rst_ctl", 32'({grant, if_ready, dm_ready, mem_en, mem_we}), 32'h0);
        chk("rst_data", if_rdata | dm_rdata | mem_addr | mem_wdata, 32'h0);
        chk("rst_dut0", 32'({grant0, if_ready0, dm_ready0, mem_en0, mem_we0}) |
            mem_addr0 | mem_wdata0 | dm_rdata0 | if_rdata0, 32'h0);

        // Release: first sampling edge serves the fetch of 0x10.
        reset = 1'b1;
        txn(n, en, rdy, g, a, w, wd);
        chk("rel_grant", 32'(g), 32'h1);
        chk("rel_latency", n, W + 2);
        chk("rel_mem_en_cycles", en, W + 1);
        chk("rel_if_rdata", if_rdata, 32'hE3A0_0007);
        exp_if_rd = 32'hE3A0_0007;
        if_req = 1'b0;
        step();
        chk("rel_ready_one_cycle", 32'({if_ready, grant}), 32'h0);
        step();

        // Table of single transactions started from IDLE.
        for (int i = 0; i < 7; i++) begin
            if_req = vt[i].ifr; if_addr = vt[i].ia;
            dm_req = vt[i].dmr; dm_we = vt[i].we; dm_addr = vt[i].da; dm_wdata = vt[i].wd;
            txn(n, en, rdy, g, a, w, wd);
            chk($sformatf("v%0d_grant", i), 32'(g), 32'(vt[i].g));
            chk($sformatf("v%0d_mem_addr", i), a, vt[i].ea);
            chk($sformatf("v%0d_mem_we", i), 32'(w), 32'(vt[i].ewe));
            if (vt[i].ewe) chk($sformatf("v%0d_mem_wdata", i), wd, vt[i].wd);
            chk($sformatf("v%0d_latency", i), n, W + 2);
            chk($sformatf("v%0d_mem_en_cycles", i), en, W + 1);
            chk($sformatf("v%0d_ready", i), 32'(rdy), 32'(vt[i].g));
            if (vt[i].g == 2'b10) begin
                if (vt[i].we) ref_write(vt[i].da, vt[i].wd);
                else exp_dm_rd = ref_rd(vt[i].da);
            end else begin
                exp_if_rd = ref_rd(vt[i].ia);
            end
            chk($sformatf("v%0d_if_rdata", i), if_rdata, exp_if_rd);
            chk($sformatf("v%0d_dm_rdata", i), dm_rdata, exp_dm_rd);
            if_req = 1'b0; dm_req = 1'b0;
            step();
            chk($sformatf("v%0d_ready_drop", i), 32'({dm_ready, if_ready}), 32'h0);
            step();
        end

        // Tie: the MEM store goes first, the fetch follows one access later.
        if_req = 1'b1; if_addr = 32'h14;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h64; dm_wdata = 32'h7;
        txn(n, en, rdy, g, a, w, wd);
        chk("tie_grant", 32'(g), 32'h2);
        chk("tie_mem_addr", a, 32'h64);
        chk("tie_mem_we", 32'(w), 32'h1);
        chk("tie_mem_wdata", wd, 32'h7);
        chk("tie_dm_ready", 32'(rdy), 32'h2);
        ref_write(32'h64, 32'h7);
        dm_req = 1'b0;
        n = 0;
        do begin step(); n++; end while (!if_ready && n < 12);
        chk("tie_if_after_dm", n, W + 3);
        exp_if_rd = ref_rd(32'h14);
        chk("tie_if_rdata", if_rdata, exp_if_rd);
        if_req = 1'b0;
        step(); step();

        // MEM re-requests continuously while IF is pending.
`ifdef ARB_FAIRNESS_EN
        gs_exp = '{2'b10, 2'b01, 2'b10};
        exp_pend = 1'b0;
`else
        gs_exp = '{2'b10, 2'b10, 2'b10};
        exp_pend = 1'b1;
`endif
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h64;
        if_req = 1'b1; if_addr = 32'h18;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin step(); n++; end while (grant == 2'b00 && n < 12);
            gs[k] = grant;
            n = 0;
            do begin step(); n++; end while (!(if_ready || dm_ready) && n < 12);
            if (if_ready) begin
                if_req = 1'b0;
                exp_if_rd = ref_rd(32'h18);
            end else if (dm_ready) begin
                exp_dm_rd = ref_rd(32'h64);
            end
            chk($sformatf("b2b_grant%0d", k), 32'(gs[k]), 32'(gs_exp[k]));
        end
        dm_req = 1'b0;
        chk("b2b_if_pending", 32'(if_req), 32'(exp_pend));
        if (if_req) begin
            n = 0;
            do begin step(); n++; end while (!if_ready && n < 12);
            chk("b2b_if_served_late", n, W + 3);
            exp_if_rd = ref_rd(32'h18);
            if_req = 1'b0;
        end
        chk("b2b_if_rdata", if_rdata, exp_if_rd);
        chk("b2b_dm_rdata", dm_rdata, exp_dm_rd);
        step(); step();

        // Reset in the middle of BUSY abandons the access.
        if_req = 1'b1; if_addr = 32'h10;
        step();
        chk("rmid_busy", 32'(mem_en), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("rmid_async", 32'({mem_en, grant, if_ready}), 32'h0);
        chk("rmid_rdata", if_rdata | dm_rdata, 32'h0);
        exp_if_rd = '0;
        exp_dm_rd = '0;
        if_req = 1'b0;
        step();
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rmid_no_ready", 32'({grant, if_ready, dm_ready}), 32'h0);
        end

        // Zero-wait-state instance.
        if_req0 = 1'b1; if_addr0 = 32'h30;
        n = 0; en = 0;
        do begin step(); n++; en += int'(mem_en0); end while (!if_ready0 && n < 12);
        chk("w0_latency", n, 2);
        chk("w0_mem_en_cycles", en, 1);
        chk("w0_if_rdata", if_rdata0, 32'h5A5A_0030);
        if_req0 = 1'b0;
        step();
        chk("w0_ready_drop", 32'(if_ready0), 32'h0);

        // Random traffic against a timeline model: an access sampled at edge s
        // owns the memory after edges s..s+W, responds after edge s+W+1 and
        // the arbiter next samples at edge s+W+3.
        s_edge = -100; nf = 0; lw = 1'b0;
        cp = 2'b00; cwe = 1'b0; ca = '0; cwd = '0;
        for (int c = 0; c < 800; c++) begin
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req  = 1'b1;
                if_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            end else if (if_req && $urandom_range(0, 19) == 0) begin
                if_req = 1'b0;
            end
            if (!dm_req && $urandom_range(0, 2) == 0) begin
                dm_req   = 1'b1;
                dm_we    = 1'($urandom_range(0, 1));
                dm_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                dm_wdata = $urandom;
            end else if (dm_req && $urandom_range(0, 19) == 0) begin
                dm_req = 1'b0;
            end
            e1 = ecnt + 1;
            if (e1 >= nf && (if_req || dm_req)) begin
`ifdef ARB_FAIRNESS_EN
                if (if_req && dm_req) win_dm = !lw;
                else win_dm = dm_req;
`else
                win_dm = dm_req;
`endif
                lw     = win_dm;
                s_edge = e1;
                nf     = e1 + W + 3;
                cp     = win_dm ? 2'b10 : 2'b01;
                cwe    = win_dm && dm_we;
                ca     = win_dm ? dm_addr : if_addr;
                cwd    = dm_wdata;
            end
            step();
            e = ecnt;
            if (e == s_edge + W + 1) begin
                if (cp == 2'b01) exp_if_rd = ref_rd(ca);
                else if (cwe) ref_write(ca, cwd);
                else exp_dm_rd = ref_rd(ca);
            end
            chk("rnd_grant", 32'(grant),
                32'((e >= s_edge && e <= s_edge + W + 1) ? cp : 2'b00));
            chk("rnd_mem_en", 32'(mem_en), 32'(e >= s_edge && e <= s_edge + W));
            if (e >= s_edge && e <= s_edge + W) begin
                chk("rnd_mem_addr", mem_addr, ca);
                chk("rnd_mem_we", 32'(mem_we), 32'(cwe));
                if (cwe) chk("rnd_mem_wdata", mem_wdata, cwd);
            end
            chk("rnd_ready", 32'({dm_ready, if_ready}),
                32'((e == s_edge + W + 1) ? cp : 2'b00));
            chk("rnd_if_rdata", if_rdata, exp_if_rd);
            chk("rnd_dm_rdata", dm_rdata, exp_dm_rd);
            if (if_ready) if_req = 1'b0;
            if (dm_ready) dm_req = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
